// File: rtl/uart_fifo_echo.sv
// UART echo transceiver: synchronised RX deserialiser -> circular FIFO -> TX serialiser.
// Frame format, parity, stop bits and FIFO depth are parameters; error flags are sticky.
module uart_fifo_echo #(
  parameter int unsigned CLK_PER_BIT = 435,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rx_i,
  output logic                        tx_o,
  input  logic                        block_i,
  input  logic                        err_clr_i,
  output logic [DATA_BITS-1:0]        last_data_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        parity_err_o,
  output logic                        frame_err_o,
  output logic                        overflow_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLK_PER_BIT * STOP_BITS);

  localparam logic [CW-1:0] HalfLast = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BitLast  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] StopLast = CW'(CLK_PER_BIT * STOP_BITS - 1);
  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [2:0]    IdxLast  = 3'(DATA_BITS - 1);
  localparam logic [AW:0]   CountMax = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CountOne = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  // Input synchroniser
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX FSM
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 frame_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    frame_done = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntOne;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == IdxLast) begin
            rx_state_d = (PARITY != 0) ? RxParity : RxStop;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntOne;
        end
      end
      RxParity: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + CntOne;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          frame_done = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + CntOne;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
    end
  end

  // Frame verdict on the stop-sample cycle
  logic stop_bad, par_bad, good, push, pop, empty, full, ovf_set;

  assign stop_bad = frame_done && !rx_sync_q;
  assign par_bad  = frame_done && (PARITY != 0) &&
                    (((^rx_shift_q) ^ rx_par_q) != (PARITY == 1));
  assign good     = frame_done && !stop_bad && !par_bad;

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] last_q;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountMax);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = good && (!full || pop);
  assign ovf_set = good && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CountOne;
    else if (pop && !push) count_d = count_q - CountOne;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
        last_q   <= rx_shift_q;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // TX FSM
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, head;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;

  assign head = mem_q[rd_ptr_q];
  assign pop  = (tx_state_q == TxIdle) && !empty && !block_i;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (pop) begin
          tx_shift_d = head;
          tx_par_d   = (PARITY == 1) ? ~(^head) : (^head);
          tx_state_d = TxStart;
          tx_d       = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = TxData;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CntOne;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IdxLast) begin
            if (PARITY != 0) begin
              tx_state_d = TxParity;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TxStop;
              tx_d       = 1'b1;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntOne;
        end
      end
      TxParity: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_state_d = TxStop;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CntOne;
        end
      end
      TxStop: begin
        if (tx_cnt_q == StopLast) begin
          tx_cnt_d   = '0;
          tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + CntOne;
        end
      end
      default: begin
        tx_state_d = TxIdle;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // Sticky flags: a set in the same cycle wins over err_clr
  logic perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  always_comb begin
    perr_d = par_bad  ? 1'b1 : (err_clr_i ? 1'b0 : perr_q);
    ferr_d = stop_bad ? 1'b1 : (err_clr_i ? 1'b0 : ferr_q);
    ovf_d  = ovf_set  ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign tx_o         = tx_q;
  assign last_data_o  = last_q;
  assign fifo_count_o = count_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;

endmodule
